// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_bist.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__nand4_bist
//
// Self-checking exerciser for the 4-input NAND functional model. It walks
// {A4,A3,A2,A1} through all 16 vectors, LOOPS times per run. Each vector is
// held SETTLE_CYC cycles in APPLY, then ZN is sampled during one SAMPLE cycle
// and compared against the ideal NAND4 result. Mismatches go into a
// saturating counter, and the verdict is reported through a START/DONE
// handshake.
//
// Parameters:
//   SETTLE_CYC  cycles each vector is held before ZN is sampled (1..15)
//   LOOPS       full 16-vector passes per run (1..255)
//   ERR_W       width of the saturating mismatch counter (2..16)
//
// Ports:
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset; overrides everything
//   START     in   run request; only looked at in IDLE or DONE
//   ZN        in   output of the NAND4 under test
//   A1..A4    out  vector bits 0..3 driven to the NAND4 (registered)
//   BUSY      out  high while a run is in progress
//   DONE      out  high from run completion until the next START or RST
//   PASS      out  meaningful while DONE=1; high when ERR_CNT==0
//   ERR_CNT   out  saturating mismatch count for the current or last run
//
// Optional feature (macro GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN):
//   FAIL_VLD  out  set on the first mismatch of a run
//   FAIL_VEC  out  {A4,A3,A2,A1} at that first mismatch
//   Both hold until RST or the next START, and clear when a run starts.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__nand4_bist #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOOPS      = 1,
    parameter int unsigned ERR_W      = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             A4,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
    ,
    output logic             FAIL_VLD,
    output logic [3:0]       FAIL_VEC
`endif
);

    // Settle counter reaches SETTLE_CYC (max 15) on the APPLY exit edge.
    localparam int unsigned SettleW = 4;
    localparam int unsigned LoopW   = 8;

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);
    localparam logic [LoopW-1:0]   LoopLast   = LoopW'(LOOPS - 1);
    localparam logic [3:0]         VecLast    = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSample,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [3:0]         vec_q, vec_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [LoopW-1:0]   loop_q, loop_d;
    logic [ERR_W-1:0]   err_q, err_d;

`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
    logic               fail_vld_q, fail_vld_d;
    logic [3:0]         fail_vec_q, fail_vec_d;
`endif

    logic start_ok;
    logic expected_zn;
    logic mismatch;
    logic err_sat;
    logic last_vec;
    logic last_loop;

    // START is only honoured between runs; a request while busy is dropped.
    assign start_ok    = START && ((state_q == StIdle) || (state_q == StDone));
    assign expected_zn = ~(&vec_q);
    // Case inequality so that an X or Z on ZN is scored as a mismatch in
    // simulation rather than silently passing.
    assign mismatch    = (state_q == StSample) && (ZN !== expected_zn);
    assign err_sat     = &err_q;
    assign last_vec    = (vec_q == VecLast);
    assign last_loop   = (loop_q == LoopLast);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                if (settle_q == SettleLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (last_vec && last_loop) begin
                    state_d = StDone;
                end else begin
                    state_d = StApply;
                end
            end
            StDone: begin
                if (start_ok) begin
                    state_d = StApply;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: vector, settle, loop and error counters
    // -----------------------------------------------------------------------
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        loop_d   = loop_q;
        err_d    = err_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    vec_d    = '0;
                    settle_d = '0;
                    loop_d   = '0;
                    err_d    = '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
                    fail_vld_d = 1'b0;
                    fail_vec_d = 4'h0;
`endif
                end
            end
            StApply: begin
                settle_d = settle_q + SettleW'(1);
            end
            StSample: begin
                if (mismatch) begin
                    if (!err_sat) begin
                        err_d = err_q + ERR_W'(1);
                    end
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_vec_d = vec_q;
                    end
`endif
                end
                if (!last_vec) begin
                    vec_d    = vec_q + 4'd1;
                    settle_d = '0;
                end else if (!last_loop) begin
                    vec_d    = 4'h0;
                    loop_d   = loop_q + LoopW'(1);
                    settle_d = '0;
                end
                // Final vector of the final loop: vec stays at 4'hF in DONE.
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vec_q    <= '0;
            settle_q <= '0;
            loop_q   <= '0;
            err_q    <= '0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            loop_q   <= loop_d;
            err_q    <= err_d;
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            fail_vld_q <= 1'b0;
            fail_vec_q <= 4'h0;
        end else begin
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;
`endif

    // -----------------------------------------------------------------------
    // Output decode (Moore: everything derives from registered state)
    // -----------------------------------------------------------------------
    always_comb begin
        BUSY    = 1'b0;
        DONE    = 1'b0;
        PASS    = 1'b0;
        unique case (state_q)
            StApply, StSample: BUSY = 1'b1;
            StDone: begin
                DONE = 1'b1;
                PASS = (err_q == '0);
            end
            default: ;
        endcase
        A1      = vec_q[0];
        A2      = vec_q[1];
        A3      = vec_q[2];
        A4      = vec_q[3];
        ERR_CNT = err_q;
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nand4_bist.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__nand4_bist;

    typedef struct {
        int         busy;
        int         pass;
        int         err;
        logic [3:0] vec;
        int         fvld;
        logic [3:0] fvec;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start1;
    logic zn0, zn1;
    int   mode0;  // 0: correct NAND4, 1: ZN tied high, 2: ZN tied low

    // dut0: defaults (SETTLE_CYC=2, LOOPS=1, ERR_W=5)
    logic       a1_0, a2_0, a3_0, a4_0, busy0, done0, pass0;
    logic [4:0] err0;
    // dut1: ERR_W=3, LOOPS=2
    logic       a1_1, a2_1, a3_1, a4_1, busy1, done1, pass1;
    logic [2:0] err1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
    logic       fvld0, fvld1;
    logic [3:0] fvec0, fvec1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   bc0 = 0, bc1 = 0;
    logic done0_prev = 1'b0, done1_prev = 1'b0;

    always_comb begin
        if (mode0 == 0) zn0 = ~(a1_0 & a2_0 & a3_0 & a4_0);
        else if (mode0 == 1) zn0 = 1'b1;
        else zn0 = 1'b0;
    end
    assign zn1 = 1'b0;

    gf180mcu_fd_sc_mcu7t5v0__nand4_bist dut0 (
        .CLK     (clk),
        .RST     (rst),
        .START   (start0),
        .ZN      (zn0),
        .A1      (a1_0),
        .A2      (a2_0),
        .A3      (a3_0),
        .A4      (a4_0),
        .BUSY    (busy0),
        .DONE    (done0),
        .PASS    (pass0),
        .ERR_CNT (err0)
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
        ,
        .FAIL_VLD(fvld0),
        .FAIL_VEC(fvec0)
`endif
    );

    gf180mcu_fd_sc_mcu7t5v0__nand4_bist #(
        .SETTLE_CYC(2),
        .LOOPS     (2),
        .ERR_W     (3)
    ) dut1 (
        .CLK     (clk),
        .RST     (rst),
        .START   (start1),
        .ZN      (zn1),
        .A1      (a1_1),
        .A2      (a2_1),
        .A3      (a3_1),
        .A4      (a4_1),
        .BUSY    (busy1),
        .DONE    (done1),
        .PASS    (pass1),
        .ERR_CNT (err1)
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
        ,
        .FAIL_VLD(fvld1),
        .FAIL_VEC(fvec1)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for dut0: counts BUSY cycles and scores each run at DONE rise.
    always @(negedge clk) begin
        exp_t e;
        if (rst) bc0 = 0;
        else if (busy0) bc0++;
        if (done0 && !done0_prev) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", 1, 0);
            end else begin
                e = q0.pop_front();
                check("dut0_busy_cycles", bc0, e.busy);
                check("dut0_pass", int'(pass0), e.pass);
                check("dut0_err_cnt", int'(err0), e.err);
                check("dut0_last_vec", int'({a4_0, a3_0, a2_0, a1_0}), int'(e.vec));
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
                check("dut0_fail_vld", int'(fvld0), e.fvld);
                if (e.fvld != 0) check("dut0_fail_vec", int'(fvec0), int'(e.fvec));
`endif
            end
            bc0 = 0;
        end
        done0_prev = done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) bc1 = 0;
        else if (busy1) bc1++;
        if (done1 && !done1_prev) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut1_busy_cycles", bc1, e.busy);
                check("dut1_pass", int'(pass1), e.pass);
                check("dut1_err_cnt", int'(err1), e.err);
                check("dut1_last_vec", int'({a4_1, a3_1, a2_1, a1_1}), int'(e.vec));
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
                check("dut1_fail_vld", int'(fvld1), e.fvld);
                if (e.fvld != 0) check("dut1_fail_vec", int'(fvec1), int'(e.fvec));
`endif
            end
            bc1 = 0;
        end
        done1_prev = done1;
    end

    task automatic wait_q0(input int budget);
        for (int i = 0; i < budget && q0.size() != 0; i++) @(negedge clk);
        check("dut0_run_completed_in_budget", q0.size(), 0);
        q0.delete();
    endtask

    task automatic wait_q1(input int budget);
        for (int i = 0; i < budget && q1.size() != 0; i++) @(negedge clk);
        check("dut1_run_completed_in_budget", q1.size(), 0);
        q1.delete();
    endtask

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_vec"}, int'({a4_0, a3_0, a2_0, a1_0}), 0);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_done"}, int'(done0), 0);
        check({tag, "_pass"}, int'(pass0), 0);
        check({tag, "_err"}, int'(err0), 0);
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAILLOG_EN
        check({tag, "_fail_vld"}, int'(fvld0), 0);
        check({tag, "_fail_vec"}, int'(fvec0), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset0("reset");
        check("reset_dut1_busy", int'(busy1), 0);
        check("reset_dut1_err", int'(err1), 0);

        // 1: correct NAND4 -> clean pass
        mode0 = 0;
        q0.push_back('{busy: 48, pass: 1, err: 0, vec: 4'hF, fvld: 0, fvec: 4'h0});
        pulse_start0();
        wait_q0(200);

        // 2: ZN stuck high -> only vector F mismatches
        mode0 = 1;
        q0.push_back('{busy: 48, pass: 0, err: 1, vec: 4'hF, fvld: 1, fvec: 4'hF});
        pulse_start0();
        wait_q0(200);

        // 3: ZN stuck low -> vectors 0..E mismatch
        mode0 = 2;
        q0.push_back('{busy: 48, pass: 0, err: 15, vec: 4'hF, fvld: 1, fvec: 4'h0});
        pulse_start0();
        wait_q0(200);

        // 5a: stray START while busy must not disturb the run length
        mode0 = 0;
        q0.push_back('{busy: 48, pass: 1, err: 0, vec: 4'hF, fvld: 0, fvec: 4'h0});
        pulse_start0();
        repeat (10) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_q0(200);

        // 5b: reset at vec 7 aborts the run without a DONE
        mode0 = 2;
        pulse_start0();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({a4_0, a3_0, a2_0, a1_0} == 4'h7) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_vec7", int'(found), 1);
        check("abort_err_before_reset", int'(err0), 7);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset0("abort");
        repeat (60) @(negedge clk);
        check("abort_still_idle_busy", int'(busy0), 0);
        check("abort_still_idle_done", int'(done0), 0);

        // 6: START held through DONE -> immediate second run
        mode0 = 2;
        q0.push_back('{busy: 48, pass: 0, err: 15, vec: 4'hF, fvld: 1, fvec: 4'h0});
        q0.push_back('{busy: 48, pass: 1, err: 0, vec: 4'hF, fvld: 0, fvec: 4'h0});
        @(posedge clk); #1 start0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done0) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b_first_done_seen", int'(found), 1);
        mode0 = 0;
        @(negedge clk);
        check("b2b_done_one_cycle", int'(done0), 0);
        check("b2b_busy_again", int'(busy0), 1);
        check("b2b_err_cleared", int'(err0), 0);
        start0 = 1'b0;
        wait_q0(200);

        // 4: narrow counter, two loops, ZN stuck low -> saturates at 7
        q1.push_back('{busy: 96, pass: 0, err: 7, vec: 4'hF, fvld: 1, fvec: 4'h0});
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        wait_q1(300);
        repeat (3) @(negedge clk);
        check("dut1_err_holds_saturated", int'(err1), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
